// File: rtl/stream_rr_mux_pkg.sv
// stream_rr_mux_pkg: shared lock-state type and parameter defaults for stream_rr_mux
package stream_rr_mux_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int N_DEF = 8;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
endpackage

// File: rtl/stream_rr_mux_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or after ptr (ports: req, ptr -> gnt_vld, gnt_idx)
module rr_arbiter #(
  parameter int N = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);
  always_comb begin
    gnt_vld = |req;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt_idx = SEL_W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/stream_rr_mux.sv
// stream_rr_mux: N-to-1 registered valid/ready stream mux with round-robin arbitration
// ports: clk, rst_n (async active-low), in_data/in_valid/in_ready per channel, out_data/out_valid/out_ready/out_sel
// STREAM_RR_MUX_LOCK_EN adds in_last/out_last and holds the grant on one channel until its last beat
module stream_rr_mux
  import stream_rr_mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N = N_DEF,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
`ifdef STREAM_RR_MUX_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);
  logic [SEL_W-1:0] rr_ptr, gnt_idx, nxt_ptr;
  logic [N-1:0] req;
  logic gnt_vld, load_en, xfer, adv;
  // rst_n gating keeps in_ready low during reset even though the slot reads as empty
  assign load_en = rst_n && (!out_valid || out_ready);
  assign xfer = load_en && gnt_vld;
  assign in_ready = xfer ? (N'(1) << gnt_idx) : '0;
  assign nxt_ptr = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  rr_arbiter #(.N(N)) u_arb (.req(req), .ptr(rr_ptr), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx));
`ifdef STREAM_RR_MUX_LOCK_EN
  lock_state_t state, state_nxt;
  logic [SEL_W-1:0] lock_ch, lock_nxt;
  assign req = (state == LOCKED) ? (in_valid & (N'(1) << lock_ch)) : in_valid;
  // pointer moves only when a packet closes, so it stays frozen across a locked packet
  assign adv = in_last[gnt_idx];
  always_comb begin
    state_nxt = state;
    lock_nxt = lock_ch;
    if (xfer) begin
      state_nxt = in_last[gnt_idx] ? IDLE : LOCKED;
      lock_nxt = gnt_idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lock_ch <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      lock_ch <= lock_nxt;
      if (xfer) out_last <= in_last[gnt_idx];
    end
`else
  assign req = in_valid;
  assign adv = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(gnt_idx) * WIDTH +: WIDTH];
      out_sel <= gnt_idx;
      if (adv) rr_ptr <= nxt_ptr;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
